// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep / configuration controller for the DDS core.
// Holds host-written shadow registers and drives the DDS phase increment,
// occupation and waveform inputs. Runs single, sawtooth-repeat or triangle
// sweeps between f_start and f_stop in f_step increments, each frequency
// held for max(dwell,1) cycles. Every output is registered.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   cfg_we/addr/wdata       host register write (0 f_start, 1 f_stop, 2 f_step,
//                           3 dwell, 4 mode {sweep_mode,occ,wave}, 5 manual inc)
//   start, stop             level-sampled sweep start / abort
//   inc_phi, occupation,    DDS controls
//   waveform
//   busy, done, err,        status: sweep active, single sweep finished pulse,
//   sweep_dir               start-rejected pulse, direction (1 = down)
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] inc_phi,
  output logic [3:0]  occupation,
  output logic [3:0]  waveform,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        sweep_dir
);

  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN} state_e;

  state_e state_q, state_d;

  // shadow registers
  logic [31:0]        fstart_q, fstop_q, fstep_q, man_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [9:0]         mode_q;

  // snapshot taken at start; sn_dwell_q already holds max(dwell,1)
  logic [31:0]        sn_start_q, sn_stop_q, sn_step_q;
  logic [DWELL_W-1:0] sn_dwell_q;
  logic [1:0]         sn_mode_q;
  logic               snap_en;

  logic [31:0]        inc_q, inc_d;
  logic [3:0]         occ_q, occ_d, wav_q, wav_d;
  logic               dir_q, dir_d, done_q, done_d, err_q, err_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  // manual inc_phi write is applied one cycle after it lands in man_q
  logic               man_pend_q, man_pend_d;

  logic [DWELL_W-1:0] dwell_ld;
  logic [32:0]        up_sum, dn_dif;
  logic [31:0]        up_nxt, dn_nxt;

  assign dwell_ld = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

  // 33-bit arithmetic so the clamps see carry/borrow instead of a wrapped value
  assign up_sum = {1'b0, inc_q} + {1'b0, sn_step_q};
  assign up_nxt = (up_sum > {1'b0, sn_stop_q}) ? sn_stop_q : up_sum[31:0];
  assign dn_dif = {1'b0, inc_q} - {1'b0, sn_step_q};
  assign dn_nxt = (dn_dif[32] || (dn_dif[31:0] < sn_start_q)) ? sn_start_q : dn_dif[31:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      dwell_q  <= DWELL_W'(1);
      mode_q   <= '0;
      man_q    <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0: fstart_q <= cfg_wdata;
        3'd1: fstop_q  <= cfg_wdata;
        3'd2: fstep_q  <= cfg_wdata;
        3'd3: dwell_q  <= cfg_wdata[DWELL_W-1:0];
        3'd4: mode_q   <= cfg_wdata[9:0];
        3'd5: man_q    <= cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sn_start_q <= '0;
      sn_stop_q  <= '0;
      sn_step_q  <= '0;
      sn_dwell_q <= DWELL_W'(1);
      sn_mode_q  <= '0;
    end else if (snap_en) begin
      sn_start_q <= fstart_q;
      sn_stop_q  <= fstop_q;
      sn_step_q  <= fstep_q;
      sn_dwell_q <= dwell_ld;
      sn_mode_q  <= mode_q[9:8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      inc_q      <= '0;
      occ_q      <= '0;
      wav_q      <= '0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      man_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inc_q      <= inc_d;
      occ_q      <= occ_d;
      wav_q      <= wav_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      man_pend_q <= man_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inc_d      = inc_q;
    occ_d      = occ_q;
    wav_d      = wav_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    snap_en    = 1'b0;
    man_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        occ_d = mode_q[7:4];
        wav_d = mode_q[3:0];
        if (man_pend_q) inc_d = man_q;
        if (cfg_we && cfg_addr == 3'd5) man_pend_d = 1'b1;
        if (start && !stop) begin
          if (fstep_q == '0 || fstart_q > fstop_q) begin
            err_d = 1'b1;
          end else begin
            // a manual write racing the start is dropped: the sweep owns inc_phi
            snap_en    = 1'b1;
            state_d    = RUN_UP;
            inc_d      = fstart_q;
            dir_d      = 1'b0;
            cnt_d      = dwell_ld;
            man_pend_d = 1'b0;
          end
        end
      end
      default: begin
        if (stop) begin
          state_d = IDLE;
          dir_d   = 1'b0;
        end else if (cnt_q <= DWELL_W'(1)) begin
          cnt_d = sn_dwell_q;
          if (state_q == RUN_UP) begin
            if (inc_q != sn_stop_q) begin
              inc_d = up_nxt;
            end else begin
              case (sn_mode_q)
                2'd1: inc_d = sn_start_q;
                2'd2: begin
                  state_d = RUN_DN;
                  dir_d   = 1'b1;
                  inc_d   = dn_nxt;
                end
                default: begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              endcase
            end
          end else begin
            if (inc_q != sn_start_q) begin
              inc_d = dn_nxt;
            end else begin
              state_d = RUN_UP;
              dir_d   = 1'b0;
              inc_d   = up_nxt;
            end
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
    endcase
  end

  assign inc_phi    = inc_q;
  assign occupation = occ_q;
  assign waveform   = wav_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign sweep_dir  = dir_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] inc_phi;
  logic [3:0]  occupation, waveform;
  logic        busy, done, err, sweep_dir;

  int n_chk = 0;
  int n_fail = 0;
  int busy_cnt;

  longint exp_inc[$];
  bit     exp_dir[$];
  bit     model_done;

  dds_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .stop(stop), .inc_phi(inc_phi),
    .occupation(occupation), .waveform(waveform), .busy(busy), .done(done),
    .err(err), .sweep_dir(sweep_dir)
  );

  always #5 clk = ~clk;

  // Frequency list from the sweep rules, each entry repeated for the dwell time.
  task automatic build(input logic [31:0] s32, e32, st32, dw32,
                       input logic [1:0] sm, input int maxcyc);
    longint s, e, st, v;
    bit dir;
    int hold;
    s = {32'b0, s32}; e = {32'b0, e32}; st = {32'b0, st32};
    exp_inc.delete(); exp_dir.delete(); model_done = 0;
    hold = (dw32 == 0) ? 1 : int'(dw32);
    v = s; dir = 0;
    while (1) begin
      for (int h = 0; h < hold; h++) begin exp_inc.push_back(v); exp_dir.push_back(dir); end
      if (exp_inc.size() >= maxcyc) return;
      if (!dir) begin
        if (v < e) v = (v + st > e) ? e : v + st;
        else if (sm == 2'd1) v = s;
        else if (sm == 2'd2) begin dir = 1; v = (v - st < s) ? s : v - st; end
        else begin model_done = 1; return; end
      end else begin
        if (v > s) v = (v - st < s) ? s : v - st;
        else begin dir = 0; v = (v + st > e) ? e : v + st; end
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] s, e, st, dw, input logic [9:0] md);
    wr(3'd0, s); wr(3'd1, e); wr(3'd2, st); wr(3'd3, dw); wr(3'd4, {22'b0, md});
  endtask

  task automatic run_sweep(input logic [31:0] s, e, st, dw, input logic [9:0] md,
                           input int maxcyc, input bit disturb, input bit b2b);
    int n;
    logic [31:0] ev;
    logic [43:0] got, expv;
    cfg(s, e, st, dw, md);
    build(s, e, st, dw, md[9:8], maxcyc);
    n = exp_inc.size();
    busy_cnt = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ev = exp_inc[i][31:0];
      got  = {busy, done, err, sweep_dir, occupation, waveform, inc_phi};
      expv = {1'b1, 1'b0, 1'b0, exp_dir[i], md[7:4], md[3:0], ev};
      if (busy) busy_cnt++;
      n_chk++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL sweep cyc %0d: got busy/done/err/dir/occ/wav/inc=%h want %h", i, got, expv);
      end
      if (disturb) begin
        if (i == 2) begin cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 32'd999; end
        if (i == 3) begin cfg_we = 1'b1; cfg_addr = 3'd4; cfg_wdata = 32'h03C; end
        if (i == 4) begin cfg_we = 1'b1; cfg_addr = 3'd5; cfg_wdata = 32'hDEAD; end
        if (i == 5) cfg_we = 1'b0;
      end
      if (!model_done && i == n - 1) begin stop = 1'b1; start = disturb; end
      @(negedge clk);
      stop = 1'b0; start = 1'b0;
    end
    if (model_done) begin
      n_chk++;
      if ({busy, done, sweep_dir, inc_phi} !== {1'b0, 1'b1, 1'b0, e}) begin
        n_fail++;
        $display("FAIL sweep end: got busy/done/dir/inc=%b%b%b %h want 010 %h", busy, done, sweep_dir, inc_phi, e);
      end
      if (b2b) begin
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_chk++;
        if ({busy, done, inc_phi} !== {1'b1, 1'b0, s}) begin
          n_fail++;
          $display("FAIL back-to-back start: got busy/done/inc=%b%b %h want 10 %h", busy, done, inc_phi, s);
        end
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b stop: busy=%b want 0", busy); end
      end else begin
        @(negedge clk);
        n_chk++;
        if ({done, inc_phi} !== {1'b0, e}) begin
          n_fail++;
          $display("FAIL after done: got done/inc=%b %h want 0 %h", done, inc_phi, e);
        end
      end
    end else begin
      ev = exp_inc[n-1][31:0];
      n_chk++;
      if ({busy, done, sweep_dir, inc_phi} !== {1'b0, 1'b0, 1'b0, ev}) begin
        n_fail++;
        $display("FAIL stop: got busy/done/dir/inc=%b%b%b %h want 000 %h", busy, done, sweep_dir, inc_phi, ev);
      end
      @(negedge clk);
      n_chk++;
      if ({busy, done, inc_phi} !== {1'b0, 1'b0, ev}) begin
        n_fail++;
        $display("FAIL stop hold: got busy/done/inc=%b%b %h want 00 %h", busy, done, inc_phi, ev);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, err, sweep_dir, occupation, waveform, inc_phi} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b%b%b%b %h %h %h want all 0", busy, done, err, sweep_dir, occupation, waveform, inc_phi);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, done, err, inc_phi} !== 35'd0) begin
      n_fail++;
      $display("FAIL post-reset idle: got %b%b%b %h want 0", busy, done, err, inc_phi);
    end
  endtask

  task automatic test_single();
    run_sweep(32'd100, 32'd130, 32'd10, 32'd3, 10'h000, 4000, 0, 0);
    n_chk++;
    if (busy_cnt !== 12) begin n_fail++; $display("FAIL single busy cycles: got %0d want 12", busy_cnt); end
  endtask

  task automatic test_clamp();
    run_sweep(32'd100, 32'd130, 32'd25, 32'd1, 10'h3A5, 4000, 0, 0);
    run_sweep(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 32'd1, 10'h012, 4000, 0, 0);
  endtask

  task automatic test_triangle();
    run_sweep(32'd100, 32'd120, 32'd10, 32'd1, 10'h200, 12, 0, 0);
    run_sweep(32'd500, 32'd500, 32'd7, 32'd2, 10'h277, 10, 0, 0);
  endtask

  task automatic test_reject();
    cfg(32'd100, 32'd130, 32'd0, 32'd1, 10'h000);
    start = 1'b1; @(negedge clk); start = 1'b0;
    n_chk++;
    if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL reject step0: got err/busy=%b%b want 10", err, busy); end
    @(negedge clk);
    n_chk++;
    if ({err, busy} !== 2'b00) begin n_fail++; $display("FAIL reject pulse width: got err/busy=%b%b want 00", err, busy); end
    cfg(32'd200, 32'd100, 32'd5, 32'd1, 10'h000);
    start = 1'b1; @(negedge clk); start = 1'b0;
    n_chk++;
    if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL reject start>stop: got err/busy=%b%b want 10", err, busy); end
    wr(3'd1, 32'd300);
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    n_chk++;
    if ({err, busy} !== 2'b00) begin n_fail++; $display("FAIL start+stop idle: got err/busy=%b%b want 00", err, busy); end
    run_sweep(32'd10, 32'd40, 32'd10, 32'd0, 10'h000, 4000, 0, 0);
  endtask

  task automatic test_shadow_stop();
    run_sweep(32'd100, 32'd130, 32'd10, 32'd2, 10'h1B4, 30, 1, 0);
    n_chk++;
    if ({occupation, waveform} !== 8'h3C) begin
      n_fail++;
      $display("FAIL shadow mode after stop: got %h%h want 3c", occupation, waveform);
    end
  endtask

  task automatic test_idle_mode();
    wr(3'd4, 32'h000); @(negedge clk);
    n_chk++;
    if ({occupation, waveform} !== 8'h00) begin n_fail++; $display("FAIL idle mode 0: got %h%h want 00", occupation, waveform); end
    wr(3'd4, 32'h0A5);
    n_chk++;
    if ({occupation, waveform} !== 8'h00) begin n_fail++; $display("FAIL idle mode early: got %h%h want 00", occupation, waveform); end
    @(negedge clk);
    n_chk++;
    if ({occupation, waveform} !== 8'hA5) begin n_fail++; $display("FAIL idle mode latency: got %h%h want a5", occupation, waveform); end
  endtask

  task automatic test_back_to_back();
    run_sweep(32'd7, 32'd9, 32'd1, 32'd2, 10'h0C3, 4000, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] s, e, st, dw;
    logic [9:0] md;
    for (int k = 0; k < 10; k++) begin
      s  = $urandom_range(0, 5000);
      e  = s + $urandom_range(0, 300);
      st = $urandom_range(1, 80);
      dw = $urandom_range(0, 4);
      md[7:0] = 8'($urandom);
      md[9:8] = 2'($urandom_range(0, 3));
      run_sweep(s, e, st, dw, md, (md[9:8] == 2'd1 || md[9:8] == 2'd2) ? 40 : 4000, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    cfg(32'd100, 32'd200, 32'd10, 32'd2, 10'h112);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, err, sweep_dir, occupation, waveform, inc_phi} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset mid-sweep: got %b%b%b%b %h %h %h want all 0", busy, done, err, sweep_dir, occupation, waveform, inc_phi);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr(3'd5, 32'h1234);
    n_chk++;
    if (inc_phi !== 32'd0) begin n_fail++; $display("FAIL manual early: got %h want 0", inc_phi); end
    @(negedge clk);
    n_chk++;
    if ({busy, done, inc_phi} !== {2'b00, 32'h1234}) begin
      n_fail++;
      $display("FAIL manual inc: got busy/done/inc=%b%b %h want 00 1234", busy, done, inc_phi);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clamp();
    test_triangle();
    test_reject();
    test_shadow_stop();
    test_idle_mode();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep and configuration controller for the DDS core. It holds a bank of software-written shadow registers and drives the DDS `inc_phi`, `occupation` and `waveform` inputs. It executes single, sawtooth-repeat or triangle sweeps between two phase increments with a programmable per-step dwell time. It sits between the host register bus and the DDS core, in the same clock domain as the core.

## Interface
- `DWELL_W`, default 16: width of the dwell counter and of the dwell register.
- `clk`  in  1: system clock, same clock as the DDS core.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cfg_we`  in  1: register write strobe, one write per cycle.
- `cfg_addr`  in  3: register address.
  - 0 = f_start
  - 1 = f_stop
  - 2 = f_step
  - 3 = dwell[DWELL_W-1:0]
  - 4 = mode: [3:0] waveform, [7:4] occupation, [9:8] sweep_mode
  - 5 = manual inc_phi
  - 6, 7 = ignored
- `cfg_wdata`  in  32: write data; unused high bits are ignored.
- `start`  in  1: level-sampled start request.
- `stop`  in  1: level-sampled abort request.
- `inc_phi`  out  32: phase increment to the DDS.
- `occupation`  out  4: duty-cycle code to the DDS.
- `waveform`  out  4: waveform select to the DDS.
- `busy`  out  1: sweep in progress.
- `done`  out  1: one-cycle pulse when a single sweep completes.
- `err`  out  1: one-cycle pulse when a start is rejected.
- `sweep_dir`  out  1: current direction, 0 = up, 1 = down.

## Operation
- **Reset values.**
  - Outputs: all 0.
  - Shadow registers: f_start = f_stop = f_step = 0, dwell = 1, mode = 0.
  - State: IDLE.
- **Writes.** Register writes always land in the shadow registers, in any state. An active sweep uses snapshot copies taken at start, so writes during a sweep do not disturb it.
- **IDLE state.**
  - `occupation` and `waveform` follow shadow mode[7:0], with 1-cycle latency.
  - `inc_phi` holds its value, except that a write to addr 5 sets `inc_phi` = wdata on the next cycle.
  - An addr-5 write while busy is discarded.
- **Start.** `start`=1 in IDLE with `stop`=0 is evaluated as follows:
  - If f_step == 0 or f_start > f_stop (unsigned): `err` pulses and the block stays in IDLE.
  - Otherwise: snapshot all shadow registers, set `inc_phi` = f_start, `sweep_dir` = 0, dwell counter = max(dwell, 1), and enter RUN_UP.
- **RUN_UP / RUN_DN states.**
  - The dwell counter decrements every cycle.
  - When it reaches 1, the next edge performs a step and reloads the counter to max(dwell, 1).
  - Each frequency is therefore held for exactly max(dwell, 1) cycles.
- **Up step.**
  - If `inc_phi` != f_stop: `inc_phi` = min(inc_phi + f_step, f_stop). The sum is computed in 33 bits, so it never wraps.
  - If `inc_phi` == f_stop, this is the endpoint:
    - sweep_mode 0 or 3 (single): go to IDLE, `busy` = 0, `done` = 1 for one cycle, `inc_phi` holds f_stop.
    - sweep_mode 1 (sawtooth): `inc_phi` = f_start, stay in RUN_UP.
    - sweep_mode 2 (triangle): go to RUN_DN, `sweep_dir` = 1, `inc_phi` = max(inc_phi − f_step, f_start). The difference is computed with 33-bit borrow, so it never wraps.
- **Down step (RUN_DN).**
  - If `inc_phi` != f_start: `inc_phi` = max(inc_phi − f_step, f_start).
  - If `inc_phi` == f_start: go to RUN_UP, `sweep_dir` = 0, `inc_phi` = min(inc_phi + f_step, f_stop).
- **Degenerate triangle.** If f_start == f_stop in triangle mode, `inc_phi` stays constant and `sweep_dir` toggles every dwell period.
- **Outputs during a sweep.** `occupation` and `waveform` come from the snapshot.
- **Stop.**
  - `stop`=1 in any RUN state: next state is IDLE, `busy` = 0, no `done` pulse, `inc_phi` holds its current value, `sweep_dir` = 0.
  - `stop` has priority over `start` and over a same-cycle endpoint.
- **Ignored starts.** `start` while busy is ignored. `start` and `stop` together in IDLE produce no start and no `err`.
- **Reset mid-sweep.** Asynchronously returns every output and register to its reset value. There is no pending `done`.

## Timing
- `start` sampled at edge T: `busy`, `inc_phi` = f_start and the snapshot `occupation`/`waveform` are all visible after edge T.
- `err` is visible after edge T, for 1 cycle.
- `stop` sampled at edge T: `busy` = 0 after edge T.
- All outputs are registered; there is no combinational path from any input to any output.
- Single sweep of N distinct frequencies with dwell D:
  - `busy` is high for exactly N·D cycles.
  - `done` is asserted in the first cycle that `busy` = 0.
- A new `start` is accepted on the same edge that `done` is visible, because the state is already IDLE.
- An addr-5 or addr-4 write in IDLE at edge T takes effect after edge T+1.

## Test plan
- **Single sweep:** f_start=100, f_stop=130, step=10, dwell=3, mode 0, start → `inc_phi` 100,110,120,130, each held 3 cycles; `busy` high 12 cycles; `done` pulses once; `inc_phi` holds 130.
- **Clamp and no-wrap:** start=100, stop=130, step=25 → 100,125,130. Then start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20 → 0xFFFFFFF0, 0xFFFFFFFF, then `done`, with no wrap to a small value.
- **Triangle:** start=100, stop=120, step=10, dwell=1, mode 2 → 100,110,120,110,100,110…; `sweep_dir` rises on the cycle showing the first 110 after 120.
- **Rejected and dwell=0:** step=0, start → `err` 1 cycle, `busy` stays 0. Then dwell=0 with a valid config → each frequency held 1 cycle.
- **Stop and shadow isolation:** sawtooth sweep running; write f_stop=999 and mode → the sweep is unchanged. Then `stop` asserted together with `start` → IDLE next cycle, no `done`, `inc_phi` frozen.
- **Reset mid-sweep:** `reset_n` low mid-sweep → all outputs 0 immediately. After release, an addr-5 write of 0x1234 in IDLE → `inc_phi` = 0x1234 one cycle later.
